multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
// - Control FSM for the multicycle RV32I core variant. Sequences one shared ALU,
//   one unified instr/data memory port and the register file across 3-5 cycles/instr.
// - Sits between the instruction register (i_op/i_funct3/i_funct7b5) and the datapath
//   muxes/enables. Supports lw, sw, R-type (add/sub/and/or/slt), beq, I-type ALU, jal.
// - Waits on the memory ready handshake.
// PARAMETERS
// - MEM_HANDSHAKE  1  1: memory states wait for i_mem_ready; 0: i_mem_ready ignored (treated as 1)
// PORTS
// - i_clk          in   1  single clock; all state updates on rising edge
// - i_rst          in   1  synchronous, active-high reset
// - i_op           in   7  opcode from instruction register (valid from DECODE on)
// - i_funct3       in   3  funct3 from instruction register
// - i_funct7b5     in   1  funct7[5] from instruction register
// - i_zero         in   1  ALU zero flag (combinational, same cycle)
// - i_mem_ready    in   1  memory access completes this cycle
// - o_alucrtl      out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
// - o_alusrca      out  2  00 PC, 01 oldPC, 10 rs1
// - o_alusrcb      out  2  00 rs2, 01 imm, 10 const 4
// - o_resultsrc    out  2  00 ALUOut reg, 01 mem data reg, 10 ALU result
// - o_immsrc       out  2  00 I, 01 S, 10 B, 11 J
// - o_adrsrc       out  1  0 PC, 1 result (data address)
// - o_irwrite      out  1  load instruction register + oldPC
// - o_pcwrite      out  1  PC write enable = pcupdate | (branch & i_zero)
// - o_memwrite     out  1  memory write strobe
// - o_regwrite     out  1  register file write enable
// - o_instr_done   out  1  1-cycle pulse in the final cycle of every instruction
// - o_illegal      out  1  1-cycle pulse: unsupported opcode decoded
// BEHAVIOUR
// - i_rst=1: state<=FETCH next edge. While i_rst=1, all enables (irwrite, pcwrite,
//   memwrite, regwrite, instr_done, illegal) forced 0; muxes 0.
//   Reset mid-instruction aborts it; first post-reset cycle is FETCH.
// - Outputs are combinational from state (Moore) except o_pcwrite (uses i_zero)
//   and memory-state enables gated by i_mem_ready.
// - States / transitions / asserted outputs (unlisted = 0):
//   FETCH:    adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10;
//             if ready: irwrite=1, pcupdate=1 -> DECODE; else stay
//   DECODE:   alusrca=01, alusrcb=10... no: alusrca=01, alusrcb=01, add, immsrc by op;
//             lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; beq -> BEQ; jal -> JAL;
//             else o_illegal=1, o_instr_done=0 -> FETCH
//   MEMADR:   alusrca=10, alusrcb=01, add; lw -> MEMREAD, sw -> MEMWRITE
//   MEMREAD:  adrsrc=1, resultsrc=00; ready -> MEMWB, else stay
//   MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 held until ready;
//             ready -> instr_done=1, FETCH
//   MEMWB:    resultsrc=01, regwrite=1, instr_done=1 -> FETCH
//   EXECR:    alusrca=10, alusrcb=00, aluop=R -> ALUWB
//   EXECI:    alusrca=10, alusrcb=01, aluop=R (sub never selected) -> ALUWB
//   ALUWB:    resultsrc=00, regwrite=1, instr_done=1 -> FETCH
//   BEQ:      alusrca=10, alusrcb=00, sub, resultsrc=00, branch=1;
//             pcwrite=i_zero, instr_done=1 -> FETCH
//   JAL:      alusrca=01, alusrcb=10, add, resultsrc=00, pcupdate=1 -> ALUWB
// - ALU decode (aluop 00 add, 01 sub, 10 by funct3): funct3=000 -> sub iff
//   i_op[5] & i_funct7b5 else add; 010 -> slt; 110 -> or; 111 -> and;
//   other funct3 -> add.
// - Immsrc in DECODE and all later states from i_op: lw/I -> 00, sw -> 01,
//   beq -> 10, jal -> 11.
// - Cycle counts with ready tied high: lw 5, sw 4, R/I 4, beq 3, jal 4.
// - i_mem_ready=0 in FETCH: no IR/PC update; outputs held.
// - Any number of wait cycles is legal.
// STRUCTURE
// - riscv_pkg: opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL),
//   ctrl_state_t enum (4-bit), alucrtl codes, aluop_t.
// - One sub-module: alu_decoder (combinational aluop/funct3/op5/funct7b5 -> o_alucrtl),
//   reused from the single-cycle controller.
// - Top: state register + next-state case + output case.
// TESTING
// - Reset: hold i_rst 2 cycles mid-MEMREAD -> state FETCH; enables 0 during reset;
//   FETCH outputs next cycle.
// - lw, op=0000011, ready=1: FETCH, DECODE, MEMADR, MEMREAD, MEMWB;
//   regwrite=1 and resultsrc=01 only in cycle 5; instr_done on cycle 5.
// - sw with ready low 3 cycles in MEMWRITE: memwrite=1 for 4 cycles;
//   instr_done only in ready cycle; regwrite never 1.
// - R-type: funct3=000, f7b5=1 -> alucrtl=001 in EXECR; funct3=010 -> 101.
//   addi: f7b5=1 -> alucrtl=000.
// - beq: zero=1 -> pcwrite=1 in BEQ; zero=0 -> pcwrite=0; both finish in 3 cycles.
// - jal: pcwrite=1 in JAL, regwrite=1 in ALUWB, immsrc=11.
//   op=1111111 -> o_illegal 1-cycle pulse in DECODE, then FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALU control codes and the ALU operation class passed to the ALU decoder.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWRITE = 4'd4,
      S_MEMWB    = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } ctrl_state_t;

   // Immediate format follows the opcode; anything without an immediate gets I.
   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_SW:   imm_sel = 2'b01;
         OP_BEQ:  imm_sel = 2'b10;
         OP_JAL:  imm_sel = 2'b11;
         default: imm_sel = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps the operation class plus funct fields to
// the ALU function code. Shared with the single-cycle controller.
module alu_decoder
   import riscv_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alucrtl
);

   always_comb begin
      alucrtl = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucrtl = ALU_ADD;
         ALUOP_SUB: alucrtl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only register-register ops can subtract; addi with imm[10]=1 stays add.
               3'b000:  alucrtl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucrtl = ALU_SLT;
               3'b110:  alucrtl = ALU_OR;
               3'b111:  alucrtl = ALU_AND;
               default: alucrtl = ALU_ADD;
            endcase
         end
         default: alucrtl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences the shared ALU, unified memory port
// and register file. o_state exposes the current state for observation.
module multicycle_ctrl_fsm
   import riscv_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic [2:0] o_alucrtl,
   output logic [1:0] o_alusrca,
   output logic [1:0] o_alusrcb,
   output logic [1:0] o_resultsrc,
   output logic [1:0] o_immsrc,
   output logic       o_adrsrc,
   output logic       o_irwrite,
   output logic       o_pcwrite,
   output logic       o_memwrite,
   output logic       o_regwrite,
   output logic       o_instr_done,
   output logic       o_illegal,
   output logic [3:0] o_state
);

   ctrl_state_t state, next_state;
   aluop_t      aluop;
   logic        mem_ready;
   logic        pcupdate;
   logic        branch;
   logic [2:0]  dec_alucrtl;

   assign mem_ready = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
   assign o_state   = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:    if (mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (i_op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = S_EXECR;
               OP_I:         next_state = S_EXECI;
               OP_BEQ:       next_state = S_BEQ;
               OP_JAL:       next_state = S_JAL;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEMADR:   next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
         S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
         S_EXECR, S_EXECI, S_JAL:  next_state = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ:  next_state = S_FETCH;
         default:    next_state = S_FETCH;
      endcase
   end

   always_comb begin
      aluop        = ALUOP_ADD;
      o_alusrca    = 2'b00;
      o_alusrcb    = 2'b00;
      o_resultsrc  = 2'b00;
      o_immsrc     = 2'b00;
      o_adrsrc     = 1'b0;
      o_irwrite    = 1'b0;
      o_memwrite   = 1'b0;
      o_regwrite   = 1'b0;
      o_instr_done = 1'b0;
      o_illegal    = 1'b0;
      pcupdate     = 1'b0;
      branch       = 1'b0;
      if (state != S_FETCH) o_immsrc = imm_sel(i_op);
      case (state)
         S_FETCH: begin
            o_alusrcb   = 2'b10;
            o_resultsrc = 2'b10;
            o_irwrite   = mem_ready;
            pcupdate    = mem_ready;
         end
         S_DECODE: begin
            o_alusrca = 2'b01;
            o_alusrcb = 2'b01;
            case (i_op)
               OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: o_illegal = 1'b0;
               default: o_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            o_alusrca = 2'b10;
            o_alusrcb = 2'b01;
         end
         S_MEMREAD:  o_adrsrc = 1'b1;
         S_MEMWRITE: begin
            o_adrsrc     = 1'b1;
            o_memwrite   = 1'b1;
            o_instr_done = mem_ready;
         end
         S_MEMWB: begin
            o_resultsrc  = 2'b01;
            o_regwrite   = 1'b1;
            o_instr_done = 1'b1;
         end
         S_EXECR: begin
            o_alusrca = 2'b10;
            aluop     = ALUOP_FUNCT;
         end
         S_EXECI: begin
            o_alusrca = 2'b10;
            o_alusrcb = 2'b01;
            aluop     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_regwrite   = 1'b1;
            o_instr_done = 1'b1;
         end
         S_BEQ: begin
            o_alusrca    = 2'b10;
            aluop        = ALUOP_SUB;
            branch       = 1'b1;
            o_instr_done = 1'b1;
         end
         S_JAL: begin
            o_alusrca = 2'b01;
            o_alusrcb = 2'b10;
            pcupdate  = 1'b1;
         end
         default: ;
      endcase
      // Reset overrides everything so an aborted instruction leaves no side effects.
      if (i_rst) begin
         aluop        = ALUOP_ADD;
         o_alusrca    = 2'b00;
         o_alusrcb    = 2'b00;
         o_resultsrc  = 2'b00;
         o_immsrc     = 2'b00;
         o_adrsrc     = 1'b0;
         o_irwrite    = 1'b0;
         o_memwrite   = 1'b0;
         o_regwrite   = 1'b0;
         o_instr_done = 1'b0;
         o_illegal    = 1'b0;
         pcupdate     = 1'b0;
         branch       = 1'b0;
      end
   end

   alu_decoder u_alu_decoder (
      .aluop    (aluop),
      .funct3   (i_funct3),
      .op5      (i_op[5]),
      .funct7b5 (i_funct7b5),
      .alucrtl  (dec_alucrtl)
   );

   assign o_alucrtl = i_rst ? ALU_ADD : dec_alucrtl;
   assign o_pcwrite = pcupdate | (branch & i_zero);

endmodule
